// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer. Hands out ROB labels (index+1, 0 = no
// producer) at issue, captures RS/LSB CDB results, answers operand-label
// queries with same-cycle CDB bypass, retires one entry per cycle and raises a
// one-cycle flush when a retiring branch resolved to a different next PC.
module reorder_buffer #(
  parameter int ROB_SIZE     = 8,
  parameter int ROB_ID_WIDTH = 3,
  parameter int VAL_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  // issue side
  input  logic                    dec2rob_en,
  input  logic [4:0]              dec_rd,
  input  logic                    dec_is_br,
  input  logic [ADDR_WIDTH-1:0]   dec_pred_pc,
  output logic                    isFull,
  output logic [ROB_ID_WIDTH:0]   newTag,
  // operand queries
  input  logic [ROB_ID_WIDTH:0]   label1,
  input  logic [ROB_ID_WIDTH:0]   label2,
  output logic                    ready1,
  output logic                    ready2,
  output logic [VAL_WIDTH-1:0]    res1,
  output logic [VAL_WIDTH-1:0]    res2,
  // result buses
  input  logic                    rs_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
  input  logic [ADDR_WIDTH-1:0]   rs_cdb2pc,
  input  logic                    lsb_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
  // retirement
  output logic                    commit_en,
  output logic [ROB_ID_WIDTH:0]   commit_lab,
  output logic [VAL_WIDTH-1:0]    commit_val,
  output logic [4:0]              commit_rd,
  output logic                    flush,
  output logic [ADDR_WIDTH-1:0]   flush_pc
);
  localparam int LW = ROB_ID_WIDTH + 1;

  // per-entry state
  logic [ROB_SIZE-1:0]                 busy_q, ready_q, is_br_q;
  logic [ROB_SIZE-1:0][4:0]            rd_q;
  logic [ROB_SIZE-1:0][ADDR_WIDTH-1:0] pred_pc_q, real_pc_q;
  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]  val_q;

  // pointers
  logic [ROB_ID_WIDTH-1:0] head_q, tail_q;
  logic [LW-1:0]           count_q;

  // registered retirement outputs
  logic                  commit_en_q, flush_q;
  logic [LW-1:0]         commit_lab_q;
  logic [VAL_WIDTH-1:0]  commit_val_q;
  logic [4:0]            commit_rd_q;
  logic [ADDR_WIDTH-1:0] flush_pc_q;

  logic alloc, do_commit, mispred;
  logic rs_hit, lsb_hit;
  logic [ROB_ID_WIDTH-1:0] rs_idx, lsb_idx;

  function automatic logic [ROB_ID_WIDTH-1:0] lab2idx(input logic [LW-1:0] lab);
    return ROB_ID_WIDTH'(lab - LW'(1));
  endfunction

  assign isFull = (count_q == LW'(ROB_SIZE));
  assign newTag = LW'(tail_q) + LW'(1);

  // Allocation is blocked while full even if the head retires this cycle;
  // a pending flush blocks retirement so nothing behind the branch leaves.
  assign alloc     = dec2rob_en && !isFull;
  assign do_commit = (count_q != '0) && ready_q[head_q] && !flush_q;
  assign mispred   = is_br_q[head_q] && (real_pc_q[head_q] != pred_pc_q[head_q]);

  assign rs_idx  = lab2idx(rs_cdb2lab);
  assign lsb_idx = lab2idx(lsb_cdb2lab);
  assign rs_hit  = rs_cdb_en  && (rs_cdb2lab  != '0) && busy_q[rs_idx];
  assign lsb_hit = lsb_cdb_en && (lsb_cdb2lab != '0) && busy_q[lsb_idx];

  // Operand query: stored result first, then same-cycle CDB bypass (RS wins).
  logic [1:0][LW-1:0]        q_lab;
  logic [1:0]                q_rdy;
  logic [1:0][VAL_WIDTH-1:0] q_res;
  assign q_lab = {label2, label1};

  always_comb begin
    q_rdy = '0;
    q_res = '0;
    for (int q = 0; q < 2; q++) begin
      if (q_lab[q] == '0) begin
        q_rdy[q] = 1'b1;
      end else if (ready_q[lab2idx(q_lab[q])]) begin
        q_rdy[q] = 1'b1;
        q_res[q] = val_q[lab2idx(q_lab[q])];
      end else if (rs_cdb_en && rs_cdb2lab == q_lab[q]) begin
        q_rdy[q] = 1'b1;
        q_res[q] = rs_cdb2val;
      end else if (lsb_cdb_en && lsb_cdb2lab == q_lab[q]) begin
        q_rdy[q] = 1'b1;
        q_res[q] = lsb_cdb2val;
      end
    end
  end

  assign ready1 = q_rdy[0];
  assign ready2 = q_rdy[1];
  assign res1   = q_res[0];
  assign res2   = q_res[1];

  // Buffer state: clear on reset/flush, otherwise retire, write back, allocate.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_en_q  <= 1'b0;
      commit_lab_q <= '0;
      commit_val_q <= '0;
      commit_rd_q  <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        busy_q       <= '0;
        ready_q      <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
        commit_en_q  <= 1'b0;
        commit_lab_q <= '0;
        commit_val_q <= '0;
        commit_rd_q  <= '0;
        flush_q      <= 1'b0;
        flush_pc_q   <= '0;
      end else begin
        commit_en_q <= do_commit;
        flush_q     <= do_commit && mispred;
        if (do_commit) begin
          commit_lab_q   <= LW'(head_q) + LW'(1);
          commit_val_q   <= val_q[head_q];
          commit_rd_q    <= rd_q[head_q];
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + ROB_ID_WIDTH'(1);
          if (mispred) flush_pc_q <= real_pc_q[head_q];
        end
        // LSB first so the RS bus wins a same-label collision
        if (lsb_hit) begin
          ready_q[lsb_idx] <= 1'b1;
          val_q[lsb_idx]   <= lsb_cdb2val;
        end
        if (rs_hit) begin
          ready_q[rs_idx]   <= 1'b1;
          val_q[rs_idx]     <= rs_cdb2val;
          real_pc_q[rs_idx] <= rs_cdb2pc;
        end
        // tail slot is never busy here, so it cannot collide with writeback
        if (alloc) begin
          busy_q[tail_q]    <= 1'b1;
          ready_q[tail_q]   <= 1'b0;
          rd_q[tail_q]      <= dec_rd;
          is_br_q[tail_q]   <= dec_is_br;
          pred_pc_q[tail_q] <= dec_pred_pc;
          tail_q            <= tail_q + ROB_ID_WIDTH'(1);
        end
        case ({alloc, do_commit})
          2'b10:   count_q <= count_q + LW'(1);
          2'b01:   count_q <= count_q - LW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign commit_en  = commit_en_q;
  assign commit_lab = commit_lab_q;
  assign commit_val = commit_val_q;
  assign commit_rd  = commit_rd_q;
  assign flush      = flush_q;
  assign flush_pc   = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation/full, bypass, in-order
// retirement, mispredict flush, pointer wrap and rdy_in stall.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        dec2rob_en, dec_is_br;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pred_pc;
  logic        isFull;
  logic [3:0]  newTag;
  logic [3:0]  label1, label2;
  logic        ready1, ready2;
  logic [31:0] res1, res2;
  logic        rs_cdb_en, lsb_cdb_en;
  logic [3:0]  rs_cdb2lab, lsb_cdb2lab;
  logic [31:0] rs_cdb2val, lsb_cdb2val, rs_cdb2pc;
  logic        commit_en, flush;
  logic [3:0]  commit_lab;
  logic [31:0] commit_val, flush_pc;
  logic [4:0]  commit_rd;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec2rob_en(dec2rob_en), .dec_rd(dec_rd), .dec_is_br(dec_is_br),
    .dec_pred_pc(dec_pred_pc), .isFull(isFull), .newTag(newTag),
    .label1(label1), .label2(label2), .ready1(ready1), .ready2(ready2),
    .res1(res1), .res2(res2),
    .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
    .rs_cdb2pc(rs_cdb2pc), .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab),
    .lsb_cdb2val(lsb_cdb2val),
    .commit_en(commit_en), .commit_lab(commit_lab), .commit_val(commit_val),
    .commit_rd(commit_rd), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; dec2rob_en = 1'b0; dec_rd = '0; dec_is_br = 1'b0;
    dec_pred_pc = '0; label1 = '0; label2 = '0;
    rs_cdb_en = 1'b0; rs_cdb2lab = '0; rs_cdb2val = '0; rs_cdb2pc = '0;
    lsb_cdb_en = 1'b0; lsb_cdb2lab = '0; lsb_cdb2val = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic [31:0] ppc);
    idle();
    dec2rob_en = 1'b1; dec_rd = rd; dec_is_br = br; dec_pred_pc = ppc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL reset_isFull: got %0h exp 0", isFull); end
    checks++; if (newTag !== 4'd1) begin errors++; $display("FAIL reset_newTag: got %0d exp 1", newTag); end
    checks++; if (commit_en !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_outputs: commit_en %0h flush %0h exp 0 0", commit_en, flush); end
    checks++; if (flush_pc !== 32'h0 || commit_lab !== 4'd0) begin errors++; $display("FAIL reset_fields: flush_pc %0h commit_lab %0h exp 0 0", flush_pc, commit_lab); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      idle();
      dec2rob_en = 1'b1; dec_rd = 5'(i + 1);
      #1;
      checks++; if (newTag !== 4'(i + 1)) begin errors++; $display("FAIL fill_newTag%0d: got %0d exp %0d", i, newTag, i + 1); end
      tick();
    end
    idle();
    checks++; if (isFull !== 1'b1) begin errors++; $display("FAIL fill_isFull: got %0h exp 1", isFull); end
    dec2rob_en = 1'b1; dec_rd = 5'd20;
    tick();
    idle();
    checks++; if (isFull !== 1'b1 || newTag !== 4'd1) begin errors++; $display("FAIL fill_ninth: isFull %0h newTag %0d exp 1 1", isFull, newTag); end
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL fill_nocommit: got %0h exp 0", commit_en); end
  endtask

  task automatic test_bypass();
    idle();
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd3; rs_cdb2val = 32'h55;
    label1 = 4'd3; label2 = 4'd4;
    #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'h55) begin errors++; $display("FAIL bypass_same_cycle: ready1 %0h res1 %0h exp 1 55", ready1, res1); end
    checks++; if (ready2 !== 1'b0 || res2 !== 32'h0) begin errors++; $display("FAIL bypass_other: ready2 %0h res2 %0h exp 0 0", ready2, res2); end
    tick();
    idle();
    label1 = 4'd3; label2 = 4'd0;
    #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'h55) begin errors++; $display("FAIL bypass_stored: ready1 %0h res1 %0h exp 1 55", ready1, res1); end
    checks++; if (ready2 !== 1'b1 || res2 !== 32'h0) begin errors++; $display("FAIL query_label0: ready2 %0h res2 %0h exp 1 0", ready2, res2); end
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL bypass_nocommit: got %0h exp 0", commit_en); end
  endtask

  task automatic test_inorder();
    idle();
    lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd2; lsb_cdb2val = 32'h22;
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL order_wait1: got %0h exp 0", commit_en); end
    idle();
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'h11;
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL order_wait2: got %0h exp 0", commit_en); end
    idle();
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_rd !== 5'd1 || commit_val !== 32'h11) begin errors++; $display("FAIL order_c1: en %0h lab %0d rd %0d val %0h exp 1 1 1 11", commit_en, commit_lab, commit_rd, commit_val); end
    checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL order_notfull: got %0h exp 0", isFull); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || commit_rd !== 5'd2 || commit_val !== 32'h22) begin errors++; $display("FAIL order_c2: en %0h lab %0d rd %0d val %0h exp 1 2 2 22", commit_en, commit_lab, commit_rd, commit_val); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd3 || commit_rd !== 5'd3 || commit_val !== 32'h55) begin errors++; $display("FAIL order_c3: en %0h lab %0d rd %0d val %0h exp 1 3 3 55", commit_en, commit_lab, commit_rd, commit_val); end
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL order_stop: got %0h exp 0", commit_en); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc(5'd0, 1'b1, 32'h100);  // label 1: correctly predicted branch
    alloc(5'd0, 1'b1, 32'h104);  // label 2: mispredicted branch
    alloc(5'd5, 1'b0, 32'h0);    // label 3: wrong-path instruction
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd1; rs_cdb2pc = 32'h100;
    tick();
    idle();
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd2; rs_cdb2pc = 32'h200;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || flush !== 1'b0) begin errors++; $display("FAIL flush_good_br: en %0h lab %0d flush %0h exp 1 1 0", commit_en, commit_lab, flush); end
    idle();
    lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd3; lsb_cdb2val = 32'h33;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || flush !== 1'b1 || flush_pc !== 32'h200) begin errors++; $display("FAIL flush_raise: en %0h lab %0d flush %0h pc %0h exp 1 2 1 200", commit_en, commit_lab, flush, flush_pc); end
    idle();
    label1 = 4'd3;
    tick();
    checks++; if (flush !== 1'b0 || commit_en !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL flush_clear_out: flush %0h en %0h pc %0h exp 0 0 0", flush, commit_en, flush_pc); end
    checks++; if (isFull !== 1'b0 || newTag !== 4'd1) begin errors++; $display("FAIL flush_clear_ptr: isFull %0h newTag %0d exp 0 1", isFull, newTag); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL flush_clear_ready: got %0h exp 0", ready1); end
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL flush_no_wrongpath: got %0h exp 0", commit_en); end
  endtask

  task automatic test_wrap();
    logic [3:0]  exp_lab [8];
    logic [4:0]  exp_rd  [8];
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 1'b0, 32'h0);
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'hA1;
    tick();
    idle();
    dec2rob_en = 1'b1; dec_rd = 5'd15;
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd2; rs_cdb2val = 32'hA2;
    #1;
    checks++; if (isFull !== 1'b1) begin errors++; $display("FAIL wrap_full_before: got %0h exp 1", isFull); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_val !== 32'hA1) begin errors++; $display("FAIL wrap_c1: en %0h lab %0d val %0h exp 1 1 a1", commit_en, commit_lab, commit_val); end
    checks++; if (isFull !== 1'b0 || newTag !== 4'd1) begin errors++; $display("FAIL wrap_blocked: isFull %0h newTag %0d exp 0 1", isFull, newTag); end
    idle();
    dec2rob_en = 1'b1; dec_rd = 5'd9;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || commit_val !== 32'hA2) begin errors++; $display("FAIL wrap_c2: en %0h lab %0d val %0h exp 1 2 a2", commit_en, commit_lab, commit_val); end
    checks++; if (isFull !== 1'b0 || newTag !== 4'd2) begin errors++; $display("FAIL wrap_simul: isFull %0h newTag %0d exp 0 2", isFull, newTag); end
    alloc(5'd10, 1'b0, 32'h0);
    checks++; if (isFull !== 1'b1 || newTag !== 4'd3 || commit_en !== 1'b0) begin errors++; $display("FAIL wrap_refill: isFull %0h newTag %0d en %0h exp 1 3 0", isFull, newTag, commit_en); end
    exp_lab = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2};
    exp_rd  = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 4) begin
        rs_cdb_en  = 1'b1; rs_cdb2lab  = exp_lab[2*c];
        rs_cdb2val = 32'h100 + 32'(exp_lab[2*c]);
        lsb_cdb_en  = 1'b1; lsb_cdb2lab = exp_lab[2*c+1];
        lsb_cdb2val = 32'h100 + 32'(exp_lab[2*c+1]);
      end
      tick();
      if (c >= 1 && c <= 8) begin
        checks++;
        if (commit_en !== 1'b1 || commit_lab !== exp_lab[c-1] || commit_rd !== exp_rd[c-1] ||
            commit_val !== 32'h100 + 32'(exp_lab[c-1])) begin
          errors++;
          $display("FAIL wrap_drain%0d: en %0h lab %0d rd %0d val %0h exp 1 %0d %0d %0h", c, commit_en,
                   commit_lab, commit_rd, commit_val, exp_lab[c-1], exp_rd[c-1], 32'h100 + 32'(exp_lab[c-1]));
        end
      end else begin
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL wrap_idle%0d: got %0h exp 0", c, commit_en); end
      end
    end
    checks++; if (isFull !== 1'b0 || newTag !== 4'd3) begin errors++; $display("FAIL wrap_end: isFull %0h newTag %0d exp 0 3", isFull, newTag); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(5'd4, 1'b0, 32'h0);
    alloc(5'd6, 1'b0, 32'h0);
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'h77;
    tick();
    idle();
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_val !== 32'h77) begin errors++; $display("FAIL stall_pre: en %0h lab %0d val %0h exp 1 1 77", commit_en, commit_lab, commit_val); end
    for (int i = 0; i < 3; i++) begin
      idle();
      rdy_in = 1'b0;
      dec2rob_en = 1'b1; dec_rd = 5'd7;
      rs_cdb_en = 1'b1; rs_cdb2lab = 4'd2; rs_cdb2val = 32'h88;
      tick();
      checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || newTag !== 4'd3) begin errors++; $display("FAIL stall_hold%0d: en %0h lab %0d newTag %0d exp 1 1 3", i, commit_en, commit_lab, newTag); end
    end
    idle();
    label2 = 4'd2;
    #1;
    checks++; if (ready2 !== 1'b0 || newTag !== 4'd3 || isFull !== 1'b0) begin errors++; $display("FAIL stall_resume: ready2 %0h newTag %0d isFull %0h exp 0 3 0", ready2, newTag, isFull); end
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL stall_nocommit: got %0h exp 0", commit_en); end
    idle();
    rs_cdb_en = 1'b1; rs_cdb2lab = 4'd2; rs_cdb2val = 32'h99;
    tick();
    idle();
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || commit_rd !== 5'd6 || commit_val !== 32'h99) begin errors++; $display("FAIL stall_after: en %0h lab %0d rd %0d val %0h exp 1 2 6 99", commit_en, commit_lab, commit_rd, commit_val); end
  endtask

  initial begin
    rst_in = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_bypass();
    test_inorder();
    test_flush();
    test_wrap();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer; the producer side of the label/ready/value protocol that the ALU reservation station and LSB consume.
- Allocates ROB labels (newTag) at issue and answers operand-label queries.
- Captures CDB results (RS and LSB).
- Retires in order, broadcasting commit_lab/commit_val to RS, LSB and register file.
- Raises flush when a branch retires with a mispredicted next PC.

Parameters:
ROB_SIZE, 8, number of entries (power of 2)
ROB_ID_WIDTH, 3, log2(ROB_SIZE); labels are ROB_ID_WIDTH+1 bits, label = index+1, 0 = "no producer"
VAL_WIDTH, 32, data width
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
dec2rob_en  in  1  allocate one entry this cycle
dec_rd  in  5  destination register (0 = none)
dec_is_br  in  1  entry is branch/jalr
dec_pred_pc  in  ADDR_WIDTH  predicted next PC of the instruction
isFull  out  1  no free entry
newTag  out  ROB_ID_WIDTH+1  label to be given to the entry allocated this cycle (tail+1)
label1, label2  in  ROB_ID_WIDTH+1  operand labels from register file
ready1, ready2  out  1  queried label's result available
res1, res2  out  VAL_WIDTH  queried result value
rs_cdb_en, lsb_cdb_en  in  1  CDB valid
rs_cdb2lab, lsb_cdb2lab  in  ROB_ID_WIDTH+1  CDB label
rs_cdb2val, lsb_cdb2val  in  VAL_WIDTH  CDB value
rs_cdb2pc  in  ADDR_WIDTH  resolved next PC (meaningful for branches only)
commit_en  out  1  one-cycle retire pulse
commit_lab  out  ROB_ID_WIDTH+1  retired label
commit_val  out  VAL_WIDTH  retired value
commit_rd  out  5  retired destination register
flush  out  1  one-cycle mispredict flush
flush_pc  out  ADDR_WIDTH  correct fetch PC

Behaviour:
- State:
  - Per entry: busy, ready, rd, is_br, pred_pc, val, real_pc.
  - head, tail (ROB_ID_WIDTH bits, wrap mod ROB_SIZE); count (ROB_ID_WIDTH+1 bits).
- Reset, or flush && rdy_in:
  - head = tail = count = 0; all busy/ready = 0.
  - All outputs 0 on the next cycle (commit_en, flush, commit_*, flush_pc).
- rdy_in low: no state changes; registered outputs hold.
- isFull = (count == ROB_SIZE), combinational. newTag = tail+1, combinational.
- Allocate when dec2rob_en && !isFull && rdy_in:
  - Entry tail gets busy = 1, ready = 0, and the dec_* fields.
  - tail++ (wraps 7 -> 0).
  - dec2rob_en while full is ignored (no state change).
- Writeback: for each CDB with en high, set busy entry (lab-1) ready = 1, val = cdb val.
  - RS CDB also writes real_pc.
  - Label 0 or non-busy entry: ignored.
  - Both CDBs in the same cycle with different labels: both written.
- Query, combinational:
  - labelN == 0: readyN = 1, resN = 0.
  - Entry ready: readyN = 1, resN = entry val.
  - Else, if a CDB in this same cycle carries labelN: readyN = 1, resN = CDB value (bypass; RS CDB takes priority over LSB CDB).
  - Otherwise readyN = 0, resN = 0.
- Commit: when count > 0 and the head entry is ready, the next edge does:
  - commit_en = 1; commit_lab = head+1; commit_val, commit_rd from the entry.
  - Head entry busy = 0; head++.
  - At most one commit per cycle.
  - commit_en drops to 0 the following cycle unless another commit occurs.
- Mispredict: at commit, if is_br && real_pc != pred_pc:
  - flush = 1, flush_pc = real_pc, registered in the same edge as commit_en.
  - The buffer clears on the following edge.
  - Entries behind the branch never commit.
- Simultaneous allocate + commit: count unchanged; head and tail both advance.
- Allocating into the slot freed by a commit in the same cycle is illegal (count == ROB_SIZE blocks allocation until the commit edge).
- Latency: allocate → earliest commit is 2 edges (CDB write on edge 1, commit on edge 2).

Test Plan:
- Reset, then allocate 8 entries with dec_rd = 1..8 → newTag = 1..8 in order; isFull = 1 after the 8th; a 9th dec2rob_en produces no change.
- CDB rs label 3 val 0x55, with label1 = 3 queried in the same cycle → ready1 = 1, res1 = 0x55 (bypass); after the edge, still ready1 = 1, res1 = 0x55.
- Labels 2 and 1 written via the LSB then RS CDB → commit order is label 1 then label 2 on consecutive cycles; commit_rd = 1, 2; commit_val matches.
- Branch with pred_pc 0x104, rs_cdb2pc 0x200 → at commit, flush = 1, flush_pc = 0x200; the next cycle has count = 0, isFull = 0, newTag = 1, commit_en = 0.
- Fill to 8, commit one while allocating one (wrap) → tail wraps to 0; the next newTag after that allocation = 2 for index 1; no lost entry.
- rdy_in low for 3 cycles while a CDB is valid → no write, no commit; resume: state identical to before the stall.
